// File: rtl/mem_pkg.sv
// Shared constants and types for the dual-port data memory.
// Holds the default widths and the clear-sequencer state encoding.
package mem_pkg;

  localparam int MEM_DATA_W = 64;
  localparam int MEM_ADDR_W = 8;
  localparam int MEM_BYTE_W = 8;
  localparam int MEM_NUM_BE = MEM_DATA_W / MEM_BYTE_W;

  typedef enum logic {
    CLEAR,
    READY
  } memState_e;

endpackage

// File: rtl/dp_mem_clear_seq.sv
// Post-reset clear sequencer for dp_data_mem_pipe.
// Sweeps zeros through every word, then hands the write port to the user.
module dp_mem_clear_seq
  import mem_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              userWrEn,
  input  logic [ADDR_W-1:0] userWrAddr,
  output logic              initBusy,
  output logic              memWrEn,
  output logic              memWrZero,
  output logic [ADDR_W-1:0] memWrAddr
);

  localparam memState_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  memState_e         state;
  memState_e         stateNext;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cntNext;
  logic              userInRange;

  assign userInRange = (32'(userWrAddr) < DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // While clearing, the sweep owns the write port and user requests are dropped.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    initBusy  = 1'b0;
    memWrEn   = 1'b0;
    memWrZero = 1'b0;
    memWrAddr = userWrAddr;
    case (state)
      CLEAR: begin
        initBusy  = 1'b1;
        memWrEn   = 1'b1;
        memWrZero = 1'b1;
        memWrAddr = cnt;
        if (cnt == LAST_ADDR) begin
          stateNext = READY;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      READY: begin
        memWrEn = userWrEn && userInRange;
      end
      default: begin
        stateNext = RESET_STATE;
      end
    endcase
  end

endmodule

// File: rtl/dp_data_mem_pipe.sv
// General-purpose data store between the MEM stage and the datapath.
// One write port with byte enables, one read port with write-first forwarding.
module dp_data_mem_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W         = MEM_DATA_W,
  parameter int ADDR_W         = MEM_ADDR_W,
  parameter int DEPTH          = 256,
  parameter int BYTE_W         = MEM_BYTE_W,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     init_busy
);

  localparam int NUM_BE = DATA_W / BYTE_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              memWrEn;
  logic              memWrZero;
  logic [ADDR_W-1:0] memWrAddr;
  logic [IDX_W-1:0]  wrIdx;
  logic [IDX_W-1:0]  rdIdx;
  logic              rdInRange;
  logic              rdAccept;
  logic              wrHit;
  logic [DATA_W-1:0] storedWord;
  logic [DATA_W-1:0] rdWord;

  dp_mem_clear_seq #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) uClearSeq (
    .clk        (clk),
    .reset      (reset),
    .userWrEn   (wr_en),
    .userWrAddr (wr_addr),
    .initBusy   (init_busy),
    .memWrEn    (memWrEn),
    .memWrZero  (memWrZero),
    .memWrAddr  (memWrAddr)
  );

  assign wrIdx = memWrAddr[IDX_W-1:0];
  assign rdIdx = rd_addr[IDX_W-1:0];

  // Storage is deliberately unreset; the clear sweep is the only initialiser.
  always_ff @(posedge clk) begin
    if (memWrEn) begin
      for (int i = 0; i < NUM_BE; i++) begin
        if (memWrZero) begin
          mem[wrIdx][i*BYTE_W +: BYTE_W] <= '0;
        end else if (wr_be[i]) begin
          mem[wrIdx][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rdInRange  = (32'(rd_addr) < DEPTH);
  assign rdAccept   = rd_en && !init_busy;
  assign wrHit      = wr_en && (wr_addr == rd_addr);
  assign storedWord = mem[rdIdx];

  // Write-first: enabled lanes of a same-address write replace the stored lanes.
  always_comb begin
    rdWord = '0;
    if (rdInRange) begin
      for (int i = 0; i < NUM_BE; i++) begin
        rdWord[i*BYTE_W +: BYTE_W] = (wrHit && wr_be[i]) ? wr_data[i*BYTE_W +: BYTE_W]
                                                         : storedWord[i*BYTE_W +: BYTE_W];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : gOutReg
      logic              s1Valid;
      logic [DATA_W-1:0] s1Data;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1Valid  <= 1'b0;
          s1Data   <= '0;
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          s1Valid  <= rdAccept;
          rd_valid <= s1Valid;
          if (rdAccept) s1Data <= rdWord;
          if (s1Valid) rd_data <= s1Data;
        end
      end
    end else begin : gNoOutReg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= rdAccept;
          if (rdAccept) rd_data <= rdWord;
        end
      end
    end
  endgenerate

endmodule
